// File: rtl/op_mem.sv
// Output-peripheral memory on the LSU bus: LED/7-seg/LCD registers with
// byte/half/word stores, 1-cycle registered readback and a multiplexed 7-seg scanner.
module op_mem #(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_lsu_wren,
    input  logic [31:0]             i_lsu_addr,
    input  logic [31:0]             i_st_data,
    input  logic [3:0]              i_num_byte,
    output logic [31:0]             o_op_data,
    output logic                    o_misalign,
    output logic [31:0]             o_io_ledr,
    output logic [31:0]             o_io_ledg,
    output logic [7*NUM_DIGITS-1:0] o_io_hex,
    output logic [31:0]             o_io_lcd,
    output logic [NUM_DIGITS-1:0]   o_seg_an,
    output logic [6:0]              o_seg_cat
);

    localparam int              DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int              DIG_W   = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    localparam logic [3:0] IDX_LEDR   = 4'h0;
    localparam logic [3:0] IDX_LEDG   = 4'h4;
    localparam logic [3:0] IDX_HEX_LO = 4'h8;
    localparam logic [3:0] IDX_HEX_HI = 4'h9;
    localparam logic [3:0] IDX_LCD    = 4'hC;

    logic [31:0]           ledr_q, ledr_d, ledg_q, ledg_d;
    logic [31:0]           hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d;
    logic [31:0]           lcd_q, lcd_d, op_data_q, op_data_d;
    logic                  misalign_q, misalign_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [DIG_W-1:0]      dig_q, dig_d;
    logic [NUM_DIGITS-1:0] seg_an_q, seg_an_d;
    logic [6:0]            seg_cat_q, seg_cat_d;

    logic        region_hit, wr_en, misalign_det, div_wrap;
    logic [3:0]  word_idx, lane_en;
    logic [31:0] wr_data;
    logic [63:0] hex_all;
    logic        unused_addr;

    // Upper address bits are deliberately don't-care (aliased region).
    assign unused_addr = ^i_lsu_addr[31:16];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  en);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = en[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return merged;
    endfunction

    // Store decode: replicate the right-aligned data across lanes, then pick lanes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        lane_en      = 4'b0000;
        wr_data      = i_st_data;
        misalign_det = 1'b0;
        region_hit   = (i_lsu_addr[15:6] == 10'b0111_0000_00);
        word_idx     = i_lsu_addr[5:2];
        case (i_num_byte)
            4'b0001: begin
                wr_data = {4{i_st_data[7:0]}};
                lane_en = 4'b0001 << i_lsu_addr[1:0];
            end
            4'b0011: begin
                wr_data = {2{i_st_data[15:0]}};
                if (i_lsu_addr[0]) misalign_det = 1'b1;
                else               lane_en = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
            end
            4'b1111: begin
                if (i_lsu_addr[1:0] != 2'b00) misalign_det = 1'b1;
                else                          lane_en = 4'b1111;
            end
            default: ;
        endcase
        wr_en = i_lsu_wren && region_hit;
    end

    always_comb begin
        ledr_d     = ledr_q;
        ledg_d     = ledg_q;
        hex_lo_d   = hex_lo_q;
        hex_hi_d   = hex_hi_q;
        lcd_d      = lcd_q;
        misalign_d = wr_en && misalign_det;
        if (wr_en) begin
            case (word_idx)
                IDX_LEDR:   ledr_d   = merge_lanes(ledr_q,   wr_data, lane_en);
                IDX_LEDG:   ledg_d   = merge_lanes(ledg_q,   wr_data, lane_en);
                IDX_HEX_LO: hex_lo_d = merge_lanes(hex_lo_q, wr_data, lane_en);
                IDX_HEX_HI: hex_hi_d = merge_lanes(hex_hi_q, wr_data, lane_en);
                IDX_LCD:    lcd_d    = merge_lanes(lcd_q,    wr_data, lane_en);
                default: ;
            endcase
        end

        // Readback uses the pre-store register values.
        op_data_d = 32'h0;
        if (region_hit) begin
            case (word_idx)
                IDX_LEDR:   op_data_d = ledr_q;
                IDX_LEDG:   op_data_d = ledg_q;
                IDX_HEX_LO: op_data_d = hex_lo_q;
                IDX_HEX_HI: op_data_d = hex_hi_q;
                IDX_LCD:    op_data_d = lcd_q;
                default: ;
            endcase
        end
    end

    // Scanner: anode and cathode both derive from dig_d so they change on the same edge.
    always_comb begin
        hex_all   = {hex_hi_q, hex_lo_q};
        div_wrap  = (div_cnt_q == DIV_MAX);
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        dig_d     = div_wrap ? dig_q + 1'b1 : dig_q;
        seg_an_d  = ~(NUM_DIGITS'(1) << dig_d);
        seg_cat_d = hex_all[8*dig_d +: 7];
        o_io_hex  = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            o_io_hex[7*k +: 7] = hex_all[8*k +: 7];
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!i_rst) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            hex_lo_q   <= '0;
            hex_hi_q   <= '0;
            lcd_q      <= '0;
            op_data_q  <= '0;
            misalign_q <= 1'b0;
            div_cnt_q  <= '0;
            dig_q      <= '0;
            seg_an_q   <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            seg_cat_q  <= '0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hex_lo_q   <= hex_lo_d;
            hex_hi_q   <= hex_hi_d;
            lcd_q      <= lcd_d;
            op_data_q  <= op_data_d;
            misalign_q <= misalign_d;
            div_cnt_q  <= div_cnt_d;
            dig_q      <= dig_d;
            seg_an_q   <= seg_an_d;
            seg_cat_q  <= seg_cat_d;
        end
    end

    assign o_io_ledr  = ledr_q;
    assign o_io_ledg  = ledg_q;
    assign o_io_lcd   = lcd_q;
    assign o_op_data  = op_data_q;
    assign o_misalign = misalign_q;
    assign o_seg_an   = seg_an_q;
    assign o_seg_cat  = seg_cat_q;

endmodule

// File: doc/op_mem.md
Name: op_mem

Overview:
- Output-peripheral memory: the store-side counterpart of the input-peripheral memory on the LSU bus.
- The LSU writes byte, half or word stores into memory-mapped registers. Those registers drive the red LEDs, green LEDs, eight 7-segment digits and the LCD.
- Supports 1-cycle registered readback so software can read-modify-write.
- Contains a time-multiplexed 7-segment scanner for boards with a shared cathode bus.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays active in the multiplexed 7-seg scan (legal range ≥ 2).
- NUM_DIGITS, 8, number of 7-seg digits; fixed at 8 for this address map.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_lsu_wren  in  1  store strobe from LSU
- i_lsu_addr  in  32  LSU byte address
- i_st_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- i_num_byte  in  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word
- o_op_data  out  32  registered readback of addressed register
- o_misalign  out  1  one-cycle pulse on a rejected misaligned store
- o_io_ledr  out  32  red LED register
- o_io_ledg  out  32  green LED register (only [7:0] physically used)
- o_io_hex  out  56  direct 7-seg: digit k = bits [7k+6:7k]
- o_io_lcd  out  32  LCD control/data register
- o_seg_an  out  8  multiplexed digit enable, one-hot, active-low
- o_seg_cat  out  7  multiplexed cathode pattern for the active digit

Behaviour:
- Region select: i_lsu_addr[15:6] == 10'b0111_0000_00 (0x7000–0x703F); upper address bits are ignored.
- Word index is addr[5:2]:
  - 0x0 (0x7000) LEDR
  - 0x4 (0x7010) LEDG
  - 0x8 (0x7020) HEX0..3, byte k = digit k
  - 0x9 (0x7024) HEX4..7, byte k = digit 4+k
  - 0xC (0x7030) LCD
  - Any other index: writes dropped, reads return 0.
- HEX registers are stored full 8-bit per byte; bit 7 of each byte is ignored on o_io_hex and o_seg_cat.
- Stores (on i_lsu_wren=1 with region hit):
  - Byte: lane = addr[1:0]; i_st_data[7:0] goes to that lane; other lanes unchanged.
  - Half: addr[0] must be 0; i_st_data[15:0] goes to lanes {addr[1],0}+1 : {addr[1],0}.
  - Word: addr[1:0] must be 0; all 4 lanes written.
  - Written values appear on the outputs the cycle after the store edge.
- Misaligned half/word store: no register changes; o_misalign=1 for exactly the next cycle.
- Illegal i_num_byte (any other code): store ignored, no misalign pulse.
- Store outside the region: ignored, no flag.
- Readback: o_op_data is the addressed register value sampled at the clock edge (1-cycle latency), always the full 32-bit word.
  - Returns pre-write data when a store to the same register occurs in the same cycle.
  - Returns 0 outside the region or for unmapped indexes.
- Scanner:
  - Counter div_cnt counts 0..SCAN_DIV-1.
  - On wrap, digit index dig (0..7) increments modulo 8.
  - o_seg_an = ~(8'b1 << dig).
  - o_seg_cat = hex byte of digit dig, bits [6:0], registered together with o_seg_an (same cycle, no glitch between them).
  - A HEX write becomes visible on o_seg_cat on the cycle after the next registered scan update for that digit. Because o_seg_cat is re-registered every cycle from the current HEX register, this is normally one cycle after the write when that digit is active.
- Reset (i_rst=0 at an edge): all registers 0, o_op_data=0, o_misalign=0, div_cnt=0, dig=0, o_seg_an=8'hFE, o_seg_cat=0.
  - Reset has priority over a simultaneous store.
  - Reset mid-scan restarts at digit 0.

Test Plan:
- Reset then word store 0xDEADBEEF to 0x7000 -> o_io_ledr=0xDEADBEEF next cycle; read 0x7000 -> o_op_data=0xDEADBEEF one cycle after the address is presented.
- Byte store 0x3F to 0x7026, then half store 0x0679 to 0x7020 -> o_io_hex digit6=0x3F, digit0=0x79, digit1=0x06, others 0.
- Half store to 0x7011 and word store to 0x7032 -> o_misalign pulses 1 cycle each; LEDG and LCD remain 0.
- SCAN_DIV=4, HEX0..3=0x01020304 -> o_seg_an steps FE, FD, FB, F7, EF, DF, BF, 7F, FE every 4 cycles; o_seg_cat=0x04 while an=FE and 0x03 while an=FD.
- Store to 0x7038 then read it, and read 0x7800 -> no output change; o_op_data=0 for both.
- Assert i_rst=0 during a word store to 0x7030 mid-scan -> LCD stays 0, o_seg_an=FE, and the scan restarts with a full SCAN_DIV dwell.
